// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART receive path.
// UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  localparam int CLKS_PER_BIT_DFLT = 16;
  localparam int HALF = CLKS_PER_BIT_DFLT / 2;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_wr_if.sv
// Async FIFO write port: data, write strobe and full flag.
// master = producer side, slave = FIFO side.
interface uart_rx_fifo_wr_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] wdata;
  logic                  winc;
  logic                  wfull;

  modport master (
    output wdata,
    output winc,
    input  wfull
  );

  modport slave (
    input  wdata,
    input  winc,
    output wfull
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with a selectable reset value.
// Also suits multi-bit gray-coded pointer crossings.
module sync_2ff #(
  parameter int   W       = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= {W{RST_VAL}};
      q    <= {W{RST_VAL}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_wr.sv
// UART receiver feeding the async FIFO write port.
// Define UART_RX_PARITY_EN to add a parity bit before stop.
module uart_rx_fifo_wr
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
  parameter int PARITY_ODD   = 0
) (
  input  logic              wrclk,
  input  logic              wrst,
  input  logic              rx,
  uart_rx_fifo_wr_if.master wr,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err,
  output logic              busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam int BW = cnt_w(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_MID = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_END = BW'(DATA_WIDTH - 1);
  localparam logic PAR_SENSE = (PARITY_ODD != 0);

  state_t                state;
  state_t                state_n;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bitn;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  winc_q;
  logic                  rx_s;
  logic                  bit_end;
  logic                  stop_smp;
  logic                  par_bad;
  logic                  fe_n;
  logic                  pe_n;
  logic                  ov_n;
  logic                  wi_n;

  sync_2ff #(
    .W      (1),
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(wrclk),
    .rst(wrst),
    .d  (rx),
    .q  (rx_s)
  );

  assign bit_end = (cnt == CNT_END);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (!rx_s) state_n = START;
      START: if (cnt == CNT_MID) state_n = rx_s ? IDLE : DATA;
      DATA: begin
        if (bit_end && bitn == BIT_END) begin
`ifdef UART_RX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_end) state_n = STOP;
`endif
      // Leave at mid-stop so a back-to-back start edge is not missed
      STOP:  if (bit_end) state_n = rx_s ? IDLE : BREAK;
      BREAK: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_q;

  always_ff @(posedge wrclk) begin
    if (wrst) begin
      par_q <= 1'b0;
    end else if (state == PARITY && bit_end) begin
      par_q <= rx_s;
    end
  end

  assign par_bad = par_q != ((^sh) ^ PAR_SENSE);
`else
  // No parity bit on the line, so never a mismatch
  assign par_bad = PAR_SENSE & 1'b0;
`endif

  assign stop_smp = (state == STOP) && bit_end;
  assign fe_n = stop_smp && !rx_s;
  assign pe_n = stop_smp && rx_s && par_bad;
  assign ov_n = stop_smp && rx_s && !par_bad && wr.wfull;
  assign wi_n = stop_smp && rx_s && !par_bad && !wr.wfull;

  always_ff @(posedge wrclk) begin
    if (wrst) begin
      state      <= IDLE;
      cnt        <= '0;
      bitn       <= '0;
      sh         <= '0;
      wdata_q    <= '0;
      winc_q     <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state || bit_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (state == DATA && bit_end) begin
        sh[bitn] <= rx_s;
        bitn     <= (bitn == BIT_END) ? '0 : bitn + 1'b1;
      end
      winc_q     <= wi_n;
      frame_err  <= fe_n;
      overrun    <= ov_n;
      parity_err <= pe_n;
      if (wi_n) begin
        wdata_q <= sh;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign wr.winc  = winc_q;
  assign wr.wdata = wdata_q;

endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// Scoreboard bench for uart_rx_fifo_wr: directed frames,
// expected pulses queued at send time and matched by a monitor.
module tb_uart_rx_fifo_wr;
  import uart_pkg::*;

  localparam int DW  = 8;
  localparam int CPB = CLKS_PER_BIT_DFLT;
  localparam int HB  = HALF;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = HB + (DW + 1 + PB) * CPB + 1 + 2;

  typedef enum int {EV_WINC, EV_FERR, EV_OVR, EV_PERR} ev_t;
  typedef struct {
    ev_t        k;
    logic [7:0] d;
    int         at;
  } exp_t;

  logic wrclk = 1'b0;
  logic wrst  = 1'b1;
  logic rx    = 1'b1;
  logic frame_err;
  logic overrun;
  logic parity_err;
  logic busy;

  uart_rx_fifo_wr_if #(.DATA_WIDTH(DW)) wr ();

  uart_rx_fifo_wr #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (PODD)
  ) dut (
    .wrclk     (wrclk),
    .wrst      (wrst),
    .rx        (rx),
    .wr        (wr),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 wrclk = ~wrclk;

  int cyc = 0;
  always @(posedge wrclk) cyc <= cyc + 1;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  logic [7:0] model_wdata = 8'h00;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cyc %0d",
               name, act, req, cyc);
    end
  endtask

  int   mon_n;
  ev_t  mon_k;
  exp_t mon_e;
  logic prev_busy = 1'b0;

  always @(negedge wrclk) begin
    if (!wrst) begin
      mon_n = int'(wr.winc) + int'(frame_err)
            + int'(overrun) + int'(parity_err);
      if (mon_n != 0) begin
        mon_k = wr.winc ? EV_WINC :
                frame_err ? EV_FERR :
                overrun ? EV_OVR : EV_PERR;
        if (q.size() == 0) begin
          check("spurious pulse", mon_n, 0);
        end else begin
          mon_e = q.pop_front();
          check("one pulse", mon_n, 1);
          check("pulse kind", int'(mon_k), int'(mon_e.k));
          check("pulse cycle", cyc, mon_e.at);
          if (mon_e.k == EV_WINC) model_wdata = mon_e.d;
          check("wdata", int'(wr.wdata), int'(model_wdata));
          check("busy at pulse", int'(busy),
                int'(mon_e.k == EV_FERR));
          check("busy before pulse", int'(prev_busy), 1);
        end
      end
    end
    prev_busy = busy;
  end

  // Caller is at a negedge; returns at the negedge ending the stop bit
  task automatic send(input logic [7:0] d, input logic stop_b,
                      input logic pflip, input ev_t k);
    exp_t e;
    e.k  = k;
    e.d  = d;
    e.at = cyc + LAT;
    q.push_back(e);
    rx = 1'b0;
    repeat (CPB) @(negedge wrclk);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge wrclk);
    end
    if (PB != 0) begin
      rx = (^d) ^ PODD[0] ^ pflip;
      repeat (CPB) @(negedge wrclk);
    end
    rx = stop_b;
    repeat (CPB) @(negedge wrclk);
  endtask

  int bcnt;
  logic [7:0] part;

  initial begin
    wr.wfull = 1'b0;
    repeat (3) @(negedge wrclk);
    check("rst winc", int'(wr.winc), 0);
    check("rst wdata", int'(wr.wdata), 0);
    check("rst frame_err", int'(frame_err), 0);
    check("rst overrun", int'(overrun), 0);
    check("rst parity_err", int'(parity_err), 0);
    check("rst busy", int'(busy), 0);
    wrst = 1'b0;
    repeat (4) @(negedge wrclk);

    send(8'hA5, 1'b1, 1'b0, EV_WINC);
    repeat (CPB) @(negedge wrclk);

    bcnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge wrclk);
      if (i == 3) rx = 1'b1;
      bcnt += int'(busy);
    end
    check("glitch busy cycles", bcnt, HB);
    check("glitch busy end", int'(busy), 0);

    send(8'h3C, 1'b0, 1'b0, EV_FERR);
    repeat (40) @(negedge wrclk);
    check("break busy", int'(busy), 1);
    rx = 1'b1;
    repeat (10) @(negedge wrclk);
    check("break released", int'(busy), 0);
    send(8'h11, 1'b1, 1'b0, EV_WINC);
    repeat (CPB) @(negedge wrclk);

    wr.wfull = 1'b1;
    send(8'h77, 1'b1, 1'b0, EV_OVR);
    wr.wfull = 1'b0;
    repeat (CPB) @(negedge wrclk);
    send(8'h5A, 1'b1, 1'b0, EV_WINC);
    repeat (CPB) @(negedge wrclk);

    send(8'h00, 1'b1, 1'b0, EV_WINC);
    send(8'hFF, 1'b1, 1'b0, EV_WINC);
    repeat (2 * CPB) @(negedge wrclk);

`ifdef UART_RX_PARITY_EN
    send(8'h01, 1'b1, 1'b1, EV_PERR);
    repeat (CPB) @(negedge wrclk);
`endif

    part = 8'h42;
    rx = 1'b0;
    repeat (CPB) @(negedge wrclk);
    for (int i = 0; i < 3; i++) begin
      rx = part[i];
      repeat (CPB) @(negedge wrclk);
    end
    wrst = 1'b1;
    rx = 1'b1;
    @(negedge wrclk);
    model_wdata = 8'h00;
    check("midrst busy", int'(busy), 0);
    check("midrst winc", int'(wr.winc), 0);
    check("midrst wdata", int'(wr.wdata), 0);
    wrst = 1'b0;
    repeat (2 * CPB) @(negedge wrclk);
    check("post rst idle", int'(busy), 0);
    send(8'h42, 1'b1, 1'b0, EV_WINC);
    repeat (2 * CPB) @(negedge wrclk);

    for (int i = 0; i < 2000 && q.size() != 0; i++) begin
      @(negedge wrclk);
    end
    check("pending events", q.size(), 0);
    check("final wdata", int'(wr.wdata), 8'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_wr.md
Name: uart_rx_fifo_wr

Overview:
UART receiver that deserialises the asynchronous rx line and drives the write port of the async FIFO in the write clock domain.
- Produces a one-cycle winc pulse with wdata for each valid frame.
- Honours the FIFO full flag and reports framing and overrun errors.
- Sits directly upstream of the FIFO write-pointer/full logic.

Parameters:
- DATA_WIDTH, 8, data bits per frame, sent LSB first.
- CLKS_PER_BIT, 16, wrclk cycles per bit. Must be even and >= 4. HALF = CLKS_PER_BIT/2.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- wrclk, input, 1, write-domain clock. All logic is on the rising edge.
- wrst, input, 1, synchronous, active-high reset.
- rx, input, 1, asynchronous serial line. Idles high.
- wfull, input, 1, FIFO full flag in the wrclk domain.
- wdata, output, DATA_WIDTH, received byte. Valid while winc = 1 and held until the next frame completes.
- winc, output, 1, one-cycle FIFO write strobe.
- frame_err, output, 1, one-cycle pulse: stop bit sampled low.
- overrun, output, 1, one-cycle pulse: valid frame dropped because wfull = 1.
- parity_err, output, 1, one-cycle pulse: parity mismatch. Tied 0 when parity is compiled out.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset (wrst = 1 at a clock edge):
  - Both rx synchroniser flops are set to 1.
  - State goes to IDLE; counters are cleared; the shift register is cleared.
  - All outputs go to 0: wdata, winc, frame_err, overrun, parity_err, busy.
  - Asserting wrst mid-frame aborts the frame silently with no pulses.
- rx synchroniser: 2-flop synchroniser producing rx_s.
- Counters:
  - cnt counts 0..CLKS_PER_BIT-1 and is cleared on every state change.
  - bitn counts 0..DATA_WIDTH-1.
- States:
  - IDLE: if rx_s = 0, go to START.
  - START: at cnt = HALF-1, sample rx_s. If 1 (glitch), go to IDLE with no pulse. If 0, go to DATA.
  - DATA: at cnt = CLKS_PER_BIT-1, sample rx_s (mid-bit) into shift-register position bitn. After bit DATA_WIDTH-1, go to PARITY if compiled in, otherwise STOP.
  - PARITY (macro only): sample at cnt = CLKS_PER_BIT-1, then go to STOP.
  - STOP: sample at cnt = CLKS_PER_BIT-1.
    - rx_s = 0: pulse frame_err and go to BREAK.
    - rx_s = 1: go to IDLE immediately at the mid-stop sample (the half-bit early return allows back-to-back frames).
  - BREAK: stay until rx_s = 1, then go to IDLE. No new frame starts while the line is held low.
- Stop-sample decision, in priority order, registered so it appears one cycle after the stop sample:
  1. frame_err.
  2. parity_err.
  3. wfull = 1: overrun.
  4. Otherwise: winc = 1 and wdata = shift register.
- Exactly one of the four pulses fires per completed frame. No output pulse lasts more than one cycle.
- Latency: winc rises HALF + (DATA_WIDTH+1)*CLKS_PER_BIT + 1 cycles after the first IDLE cycle that sees rx_s = 0. Add CLKS_PER_BIT when parity is enabled. Add 2 cycles from the rx pin for the synchroniser.
- wfull is sampled only in the stop-sample cycle. If wfull changes at other times, the frame is unaffected.
- wdata changes only on a winc cycle. It is never updated for dropped or errored frames.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - PARITY state exists.
  - Expected parity = XOR of the data bits, inverted when PARITY_ODD = 1.
  - On mismatch: parity_err pulse, no winc, return to IDLE (BREAK only if the stop bit is also low; frame_err then takes priority).
- Undefined:
  - No PARITY state; the frame is 1 start + DATA_WIDTH data + 1 stop.
  - parity_err is constant 0.

Decomposition:
- Package uart_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP, BREAK;
  - localparam HALF;
  - a counter-width function computing clog2(CLKS_PER_BIT).
- Sub-module sync_2ff (parameterised reset value, here 1) holds the rx synchroniser. It is reusable for the pointer crossings.

Test Plan:
1. CLKS_PER_BIT = 16, send 0xA5, wfull = 0 -> single winc pulse exactly 8+144+1+2 = 155 cycles after the rx falling edge; wdata = 0xA5; busy falls the cycle after the stop sample.
2. rx low for 4 cycles, then high -> no winc or error pulses; busy high for at most 9 cycles, then 0.
3. Frame 0x3C with stop bit low, rx then held low for 40 cycles -> one frame_err pulse, no winc, busy stays 1 until rx returns high, wdata unchanged; the next frame 0x11 is received cleanly.
4. wfull = 1 during the stop sample of 0x77 -> one overrun pulse, no winc, wdata keeps its old value; next frame 0x5A with wfull = 0 -> winc, wdata = 0x5A.
5. Back-to-back frames 0x00 then 0xFF with no idle gap -> two winc pulses exactly 160 cycles apart, data correct.
6. With UART_RX_PARITY_EN, PARITY_ODD = 0: 0x01 with parity bit 0 -> parity_err, no winc; assert wrst for 1 cycle mid-frame of 0x42 -> all outputs 0, state IDLE, the following 0x42 frame is received correctly.
